// File: rtl/sr_latch_driver.sv
// Command-side controller for an external cross-coupled NAND SR latch:
// issues one active-low pulse on Sbar or Rbar, lets the latch settle, then reads Q back.
module sr_latch_driver #(
  parameter int PULSE_W = 4,
  parameter int SETTLE  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_set,
  output logic       cmd_ready,
  output logic       Sbar,
  output logic       Rbar,
  input  logic       Q,
  output logic       done,
  output logic       q_err,
  output logic       q_state,
  output logic [1:0] fsm_state
);

  // Handshake: a command transfers on a rising clk edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is a flop, never a function of cmd_valid.

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PULSE  = 2'd1;
  localparam logic [1:0] SETTLE_ST = 2'd2;
  localparam logic [1:0] CHECK  = 2'd3;

  localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_W - 1);
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE - 1);

  logic [1:0] state;
  logic [7:0] cnt;
  logic       expected;
  logic       sync_a;
  logic       sync_q;

  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      expected  <= 1'b0;
      sync_a    <= 1'b0;
      sync_q    <= 1'b0;
      Sbar      <= 1'b1;
      Rbar      <= 1'b1;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      q_err     <= 1'b0;
      q_state   <= 1'b0;
    end else begin
      sync_a <= Q;
      sync_q <= sync_a;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            // Only one input leaves the high state on this edge, so the
            // latch never sees Sbar and Rbar low together.
            expected  <= cmd_set;
            cnt       <= PULSE_LOAD;
            Sbar      <= ~cmd_set;
            Rbar      <= cmd_set;
            cmd_ready <= 1'b0;
            state     <= PULSE;
          end
        end
        PULSE: begin
          if (cnt == 8'd0) begin
            Sbar  <= 1'b1;
            Rbar  <= 1'b1;
            cnt   <= SETTLE_LOAD;
            state <= SETTLE_ST;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SETTLE_ST: begin
          if (cnt == 8'd0) begin
            done    <= 1'b1;
            q_err   <= sync_q ^ expected;
            q_state <= sync_q;
            state   <= CHECK;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: behavioural NAND latch on Q, cycle timeline model
// of the pulse/settle/check sequence, randomized command stream.
module tb_sr_latch_driver;

  localparam int PW = 4;
  localparam int S  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_set = 1'b0;
  logic       cmd_ready;
  logic       Sbar;
  logic       Rbar;
  logic       Q;
  logic       done;
  logic       q_err;
  logic       q_state;
  logic [1:0] fsm_state;

  logic       latch_q = 1'b0;
  logic       tie_low = 1'b0;
  logic       mon_en = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  sr_latch_driver #(.PULSE_W(PW), .SETTLE(S)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_set(cmd_set),
    .cmd_ready(cmd_ready), .Sbar(Sbar), .Rbar(Rbar), .Q(Q), .done(done),
    .q_err(q_err), .q_state(q_state), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  always @(Sbar or Rbar) begin
    if (Sbar === 1'b0) latch_q = 1'b1;
    else if (Rbar === 1'b0) latch_q = 1'b0;
  end
  assign Q = tie_low ? 1'b0 : latch_q;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  always @(negedge clk) if (mon_en) chk("no_overlap", {7'd0, Sbar | Rbar}, 8'd1);
  always @(posedge clk) if (mon_en) begin
    #1;
    chk("no_overlap_edge", {7'd0, Sbar | Rbar}, 8'd1);
  end

  // Called at a negedge; checks quiet idle behaviour for n cycles.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_sbar", {7'd0, Sbar}, 8'd1);
      chk("idle_rbar", {7'd0, Rbar}, 8'd1);
      chk("idle_ready", {7'd0, cmd_ready}, 8'd1);
      chk("idle_done", {7'd0, done}, 8'd0);
    end
  endtask

  // Called at a negedge in IDLE. Cycle k counts from the accepting edge.
  task automatic run_cmd(input logic set, input logic tie0, input logic hold);
    logic [1:0] item;
    logic       result;
    tie_low   = tie0;
    cmd_valid = 1'b1;
    cmd_set   = set;
    chk("ready_before_accept", {7'd0, cmd_ready}, 8'd1);
    result = tie0 ? 1'b0 : set;
    exp_q.push_back({result != set, result});
    @(posedge clk);
    for (int k = 0; k <= PW + S + 1; k++) begin
      @(negedge clk);
      chk("sbar", {7'd0, Sbar}, (set && k < PW) ? 8'd0 : 8'd1);
      chk("rbar", {7'd0, Rbar}, (!set && k < PW) ? 8'd0 : 8'd1);
      chk("ready", {7'd0, cmd_ready}, (k >= PW + S + 1) ? 8'd1 : 8'd0);
      chk("done", {7'd0, done}, (k == PW + S) ? 8'd1 : 8'd0);
      if (k == PW + S) begin
        item = exp_q.pop_front();
        chk("q_err", {7'd0, q_err}, {7'd0, item[1]});
        chk("q_state", {7'd0, q_state}, {7'd0, item[0]});
      end
      if (k < PW + S) begin
        cmd_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
        cmd_set   = 1'($urandom_range(0, 1));
      end else if (k == PW + S) begin
        cmd_valid = hold;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values, during and after reset
    repeat (3) @(negedge clk);
    chk("rst_sbar", {7'd0, Sbar}, 8'd1);
    chk("rst_rbar", {7'd0, Rbar}, 8'd1);
    chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_q_state", {7'd0, q_state}, 8'd0);
    reset  = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Set, reset, Q stuck low, repeated command
    run_cmd(1'b1, 1'b0, 1'b0);
    idle(1);
    run_cmd(1'b0, 1'b0, 1'b0);
    idle(1);
    run_cmd(1'b1, 1'b1, 1'b0);
    idle(1);
    run_cmd(1'b0, 1'b0, 1'b0);
    run_cmd(1'b0, 1'b0, 1'b0);

    // cmd_valid held high, alternating direction, back to back
    for (int i = 0; i < 6; i++) run_cmd(1'(i % 2 == 0), 1'b0, 1'b1);
    cmd_valid = 1'b0;
    idle(2);

    // Reset during the second PULSE cycle
    cmd_valid = 1'b1;
    cmd_set   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_pulse_low", {7'd0, Sbar}, 8'd0);
    #1 reset = 1'b1;
    #1;
    chk("abort_sbar", {7'd0, Sbar}, 8'd1);
    chk("abort_rbar", {7'd0, Rbar}, 8'd1);
    chk("abort_ready", {7'd0, cmd_ready}, 8'd1);
    chk("abort_q_state", {7'd0, q_state}, 8'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < PW + S + 2; i++) begin
      @(negedge clk);
      chk("abort_no_done", {7'd0, done}, 8'd0);
    end
    run_cmd(1'b0, 1'b0, 1'b0);
    run_cmd(1'b1, 1'b0, 1'b0);

    // Randomized command stream
    for (int i = 0; i < 16; i++) begin
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'b0);
      idle($urandom_range(0, 3));
    end

    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
